// File: rtl/axi_node_pkg.sv
// Shared constants and helpers for the AXI node write-address path.
package axi_node_pkg;

  localparam int unsigned ARB_RR  = 0;
  localparam int unsigned ARB_QOS = 1;

  // Effective priority is 5 bits so an aged request (16) outranks any awqos value.
  localparam int unsigned       PRIO_W   = 5;
  localparam logic [PRIO_W-1:0] QOS_AGED = 5'd16;

  function automatic int unsigned aw_payload_w(input int unsigned id_w,
                                               input int unsigned addr_w,
                                               input int unsigned user_w);
    return id_w + addr_w + 8 + 3 + 2 + 1 + 4 + 3 + 4 + user_w + 4;
  endfunction

endpackage

// File: rtl/axi_qos_rr_arbiter.sv
// Highest-priority arbiter with round-robin tie-break starting at an internal pointer.
module axi_qos_rr_arbiter
  import axi_node_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned PW    = PRIO_W,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [N-1:0][PW-1:0]  prio,
  input  logic                  advance,
  output logic                  gnt_valid,
  output logic [N-1:0]          gnt_oh,
  output logic [IDX_W-1:0]      gnt_idx
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    max_prio;

  always_comb begin
    int unsigned      pos;
    logic [IDX_W-1:0] p;
    logic             found;
    pos      = '0;
    p        = '0;
    found    = 1'b0;
    max_prio = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && prio[i] > max_prio) max_prio = prio[i];
    end
    // First requester at the top priority, scanning upward from rr_ptr with wrap.
    gnt_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= N) pos = pos - N;
      p = IDX_W'(pos);
      if (!found && req[p] && prio[p] == max_prio) begin
        found   = 1'b1;
        gnt_idx = p;
      end
    end
    gnt_valid = |req;
    gnt_oh    = '0;
    if (gnt_valid) gnt_oh[gnt_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (advance) rr_ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/axi_aw_qos_allocator.sv
// AW allocator for one master port: QoS/RR arbitration, aging, one-entry output stage.
module axi_aw_qos_allocator
  import axi_node_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_W = 32,
  parameter int unsigned AXI_USER_W    = 6,
  parameter int unsigned N_TARG_PORT   = 8,
  parameter int unsigned LOG_N_TARG    = $clog2(N_TARG_PORT),
  parameter int unsigned AXI_ID_IN     = 16,
  parameter int unsigned AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
  parameter int unsigned ARB_MODE      = 1,
  parameter int unsigned AGE_W         = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]      awid_i,
  input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]  awaddr_i,
  input  logic [N_TARG_PORT-1:0][7:0]                awlen_i,
  input  logic [N_TARG_PORT-1:0][2:0]                awsize_i,
  input  logic [N_TARG_PORT-1:0][1:0]                awburst_i,
  input  logic [N_TARG_PORT-1:0]                     awlock_i,
  input  logic [N_TARG_PORT-1:0][3:0]                awcache_i,
  input  logic [N_TARG_PORT-1:0][2:0]                awprot_i,
  input  logic [N_TARG_PORT-1:0][3:0]                awregion_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]     awuser_i,
  input  logic [N_TARG_PORT-1:0][3:0]                awqos_i,
  input  logic [N_TARG_PORT-1:0]                     awvalid_i,
  output logic [N_TARG_PORT-1:0]                     awready_o,
  output logic [AXI_ID_OUT-1:0]                      awid_o,
  output logic [AXI_ADDRESS_W-1:0]                   awaddr_o,
  output logic [7:0]                                 awlen_o,
  output logic [2:0]                                 awsize_o,
  output logic [1:0]                                 awburst_o,
  output logic                                       awlock_o,
  output logic [3:0]                                 awcache_o,
  output logic [2:0]                                 awprot_o,
  output logic [3:0]                                 awregion_o,
  output logic [AXI_USER_W-1:0]                      awuser_o,
  output logic [3:0]                                 awqos_o,
  output logic                                       awvalid_o,
  input  logic                                       awready_i,
  output logic                                       push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]          ID_o,
  input  logic                                       grant_FIFO_ID_i
);

  localparam int unsigned      AwW    = aw_payload_w(AXI_ID_IN, AXI_ADDRESS_W, AXI_USER_W);
  localparam logic [AGE_W-1:0] AgeMax = '1;

  logic [N_TARG_PORT-1:0][PRIO_W-1:0] prio;
  logic [N_TARG_PORT-1:0][AGE_W-1:0]  age_q, age_d;
  logic [N_TARG_PORT-1:0][AwW-1:0]    pay_in;
  logic [AwW-1:0]                     pay_q;
  logic [LOG_N_TARG-1:0]              idx_q, gnt_idx;
  logic [N_TARG_PORT-1:0]             gnt_oh;
  logic [AXI_ID_IN-1:0]               id_q;
  logic                               awvalid_q, gnt_valid, load;

  always_comb begin
    pay_in = '0;
    prio   = '0;
    for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
      pay_in[i] = {awid_i[i], awaddr_i[i], awlen_i[i], awsize_i[i], awburst_i[i], awlock_i[i],
                   awcache_i[i], awprot_i[i], awregion_i[i], awuser_i[i], awqos_i[i]};
      if (ARB_MODE == ARB_QOS) begin
        prio[i] = (age_q[i] == AgeMax) ? QOS_AGED : {1'b0, awqos_i[i]};
      end
    end
  end

  axi_qos_rr_arbiter #(
    .N     (N_TARG_PORT),
    .PW    (PRIO_W),
    .IDX_W (LOG_N_TARG)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (awvalid_i),
    .prio      (prio),
    .advance   (load),
    .gnt_valid (gnt_valid),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx)
  );

  // Reset qualifies the accept so no port is acknowledged while rst_n is low.
  assign load = rst_n & gnt_valid & grant_FIFO_ID_i & (~awvalid_q | awready_i);

  always_comb begin
    age_d = age_q;
    if (ARB_MODE == ARB_QOS) begin
      for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
        if (!awvalid_i[i] || (load && gnt_oh[i])) age_d[i] = '0;
        else if (age_q[i] != AgeMax)              age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q     <= '0;
      pay_q     <= '0;
      idx_q     <= '0;
      awvalid_q <= 1'b0;
    end else begin
      age_q <= age_d;
      if (load) begin
        pay_q     <= pay_in[gnt_idx];
        idx_q     <= gnt_idx;
        awvalid_q <= 1'b1;
      end else if (awready_i) begin
        awvalid_q <= 1'b0;
      end
    end
  end

  assign {id_q, awaddr_o, awlen_o, awsize_o, awburst_o, awlock_o, awcache_o, awprot_o,
          awregion_o, awuser_o, awqos_o} = pay_q;
  assign awid_o    = {idx_q, id_q};
  assign awvalid_o = awvalid_q;
  assign awready_o = load ? gnt_oh : '0;
  assign push_ID_o = load;
  assign ID_o      = load ? {gnt_idx, gnt_oh} : '0;

endmodule

// File: tb/tb_axi_aw_qos_allocator.sv
// Randomized bench: a QoS/aging instance and a round-robin instance against a reference model.
module tb_axi_aw_qos_allocator;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][15:0] awid;
  logic [N-1:0][31:0] awaddr;
  logic [N-1:0][7:0]  awlen;
  logic [N-1:0][2:0]  awsize;
  logic [N-1:0][1:0]  awburst;
  logic [N-1:0]       awlock;
  logic [N-1:0][3:0]  awcache;
  logic [N-1:0][2:0]  awprot;
  logic [N-1:0][3:0]  awregion;
  logic [N-1:0][5:0]  awuser;
  logic [N-1:0][3:0]  awqos;
  logic [N-1:0]       valid;
  logic               awready_in, grant;

  logic [N-1:0] rdy_o  [2];
  logic         push_o [2];
  logic [10:0]  id_o   [2];
  logic         vld_o  [2];
  logic [85:0]  out_o  [2];

  // Instance 0: QoS with AGE_W=2; instance 1: round-robin only.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [18:0] awid_w;
    logic [31:0] addr_w;
    logic [7:0]  len_w;
    logic [2:0]  size_w, prot_w;
    logic [1:0]  burst_w;
    logic        lock_w;
    logic [3:0]  cache_w, region_w, qos_w;
    logic [5:0]  user_w;

    axi_aw_qos_allocator #(
      .AXI_ADDRESS_W (32),
      .AXI_USER_W    (6),
      .N_TARG_PORT   (8),
      .LOG_N_TARG    (3),
      .AXI_ID_IN     (16),
      .AXI_ID_OUT    (19),
      .ARB_MODE      ((g == 0) ? 1 : 0),
      .AGE_W         ((g == 0) ? 2 : 4)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .awid_i          (awid),
      .awaddr_i        (awaddr),
      .awlen_i         (awlen),
      .awsize_i        (awsize),
      .awburst_i       (awburst),
      .awlock_i        (awlock),
      .awcache_i       (awcache),
      .awprot_i        (awprot),
      .awregion_i      (awregion),
      .awuser_i        (awuser),
      .awqos_i         (awqos),
      .awvalid_i       (valid),
      .awready_o       (rdy_o[g]),
      .awid_o          (awid_w),
      .awaddr_o        (addr_w),
      .awlen_o         (len_w),
      .awsize_o        (size_w),
      .awburst_o       (burst_w),
      .awlock_o        (lock_w),
      .awcache_o       (cache_w),
      .awprot_o        (prot_w),
      .awregion_o      (region_w),
      .awuser_o        (user_w),
      .awqos_o         (qos_w),
      .awvalid_o       (vld_o[g]),
      .awready_i       (awready_in),
      .push_ID_o       (push_o[g]),
      .ID_o            (id_o[g]),
      .grant_FIFO_ID_i (grant)
    );

    assign out_o[g] = {awid_w, addr_w, len_w, size_w, burst_w, lock_w, cache_w, prot_w,
                       region_w, user_w, qos_w};
  end

  // Reference model state, one set per instance.
  int          rr      [2];
  int          age     [2][N];
  bit          ovld    [2];
  logic [85:0] oreg    [2];
  int          last_w  [2];
  logic [10:0] last_id [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int age_max(input int m);
    return (m == 0) ? 3 : 15;
  endfunction

  function automatic logic [85:0] port_vec(input int p);
    logic [2:0] ix;
    ix = 3'(p);
    return {ix, awid[p], awaddr[p], awlen[p], awsize[p], awburst[p], awlock[p], awcache[p],
            awprot[p], awregion[p], awuser[p], awqos[p]};
  endfunction

  // Highest effective priority wins; strict '>' keeps the earliest port in scan order on ties.
  function automatic int pick(input int m);
    int best;
    int pr [N];
    best = -1;
    for (int p = 0; p < N; p++) begin
      if (m == 0) pr[p] = (age[m][p] == age_max(m)) ? 16 : int'(awqos[p]);
      else        pr[p] = 0;
    end
    for (int k = 0; k < N; k++) begin
      int p;
      p = (rr[m] + k) % N;
      if (valid[p] && (best < 0 || pr[p] > pr[best])) best = p;
    end
    return best;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      int         w;
      bit         ld;
      logic [7:0] exp_rdy;
      logic [2:0] wi;
      logic [10:0] exp_id;
      w       = pick(m);
      ld      = (w >= 0) && grant && (!ovld[m] || awready_in);
      wi      = 3'(w);
      exp_rdy = ld ? (8'b1 << w) : 8'h0;
      exp_id  = ld ? {wi, exp_rdy} : 11'h0;
      check($sformatf("awready_o[%0d]", m), rdy_o[m], exp_rdy);
      check($sformatf("push_ID_o[%0d]", m), push_o[m], ld);
      check($sformatf("ID_o[%0d]", m), id_o[m], exp_id);
      check($sformatf("awvalid_o[%0d]", m), vld_o[m], ovld[m]);
      check($sformatf("payload[%0d]", m), out_o[m], oreg[m]);
      last_id[m] = id_o[m];
      if (m == 0) begin
        for (int p = 0; p < N; p++) begin
          if (!valid[p] || (ld && p == w)) age[m][p] = 0;
          else if (age[m][p] < age_max(m)) age[m][p]++;
        end
      end
      if (ld) begin
        oreg[m] = port_vec(w);
        ovld[m] = 1'b1;
        rr[m]   = (w + 1) % N;
      end else if (awready_in) begin
        ovld[m] = 1'b0;
      end
      last_w[m] = ld ? w : -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("rst_awvalid[%0d]", m), vld_o[m], 1'b0);
      check($sformatf("rst_awready[%0d]", m), rdy_o[m], 8'h0);
      check($sformatf("rst_push[%0d]", m), push_o[m], 1'b0);
      check($sformatf("rst_payload[%0d]", m), out_o[m], 86'h0);
      rr[m]      = 0;
      ovld[m]    = 1'b0;
      oreg[m]    = '0;
      last_w[m]  = -1;
      last_id[m] = '0;
      for (int p = 0; p < N; p++) age[m][p] = 0;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    for (int p = 0; p < N; p++) begin
      awid[p]     = 16'($urandom);
      awaddr[p]   = $urandom;
      awlen[p]    = 8'($urandom);
      awsize[p]   = 3'($urandom);
      awburst[p]  = 2'($urandom);
      awlock[p]   = 1'($urandom);
      awcache[p]  = 4'($urandom);
      awprot[p]   = 3'($urandom);
      awregion[p] = 4'($urandom);
      awuser[p]   = 6'($urandom);
    end
  endtask

  initial begin
    int          age_hit;
    logic [85:0] hold;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0;
    awcache = '0; awprot = '0; awregion = '0; awuser = '0; awqos = '0;
    valid = '0; awready_in = 1'b0; grant = 1'b0;
    #1;
    do_reset();

    // Round-robin fairness: all ports valid, no backpressure.
    valid = '1; awready_in = 1'b1; grant = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rand_payload();
      step();
      check("rr_sequence", last_w[1], k % N);
    end

    // QoS priority with round-robin tie-break.
    do_reset();
    valid = 8'b0110_0100;
    awqos = '0; awqos[2] = 4'd3; awqos[5] = 4'd9; awqos[6] = 4'd9;
    rand_payload(); step();
    check("qos_first_id", last_id[0], {3'd5, 8'b0010_0000});
    if (last_w[0] >= 0) valid[last_w[0]] = 1'b0;
    rand_payload(); step();
    check("qos_second", last_w[0], 6);
    if (last_w[0] >= 0) valid[last_w[0]] = 1'b0;
    rand_payload(); step();
    check("qos_third", last_w[0], 2);

    // Aging: low-priority port 1 against two qos=15 ports.
    do_reset();
    valid = 8'b0001_1010;
    awqos = '0; awqos[3] = 4'd15; awqos[4] = 4'd15;
    age_hit = 99;
    for (int k = 0; k < 8; k++) begin
      rand_payload();
      step();
      if (age_hit == 99 && last_w[0] == 1) age_hit = k;
    end
    check("aging_grant_cycle", age_hit, 3);

    // W-FIFO backpressure: registered request drains, no new accept.
    valid = '1; awready_in = 1'b1; grant = 1'b1;
    rand_payload(); step();
    grant = 1'b0;
    rand_payload(); step();
    check("bp_no_grant", last_w[0], -1);
    check("bp_drained", vld_o[0], 1'b0);
    grant = 1'b1;
    rand_payload(); step();
    check("bp_resume", (last_w[0] >= 0), 1'b1);

    // Downstream stall for five cycles.
    awready_in = 1'b0;
    hold = out_o[0];
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      step();
      check("stall_hold", out_o[0], hold);
      check("stall_no_grant", last_w[0], -1);
    end
    awready_in = 1'b1;
    rand_payload(); step();
    check("stall_release", (last_w[0] >= 0), 1'b1);

    // Reset while the output stage is full and counters are non-zero.
    awready_in = 1'b0;
    rand_payload(); step();
    do_reset();
    awready_in = 1'b1;
    rand_payload(); step();
    check("rst_restart_rr", last_w[1], 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      for (int p = 0; p < N; p++) awqos[p] = 4'($urandom);
      valid      = 8'($urandom);
      awready_in = ($urandom_range(0, 3) != 0);
      grant      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_aw_qos_allocator.md
# axi_aw_qos_allocator

Parametrised write-address allocator for one master port of the AXI node. It arbitrates AW requests from N_TARG_PORT slave ports using either plain round-robin or QoS priority with starvation aging. The winner is registered in a one-entry output stage that drives the downstream AW channel. In the same cycle, the winner's routing ID is pushed to the W-channel allocator FIFO.

## Interface
- AXI_ADDRESS_W, 32, address width
- AXI_USER_W, 6, awuser width
- N_TARG_PORT, 8, number of requesting slave ports (≥2)
- LOG_N_TARG, $clog2(N_TARG_PORT), binary port-index width
- AXI_ID_IN, 16, incoming ID width
- AXI_ID_OUT, AXI_ID_IN+LOG_N_TARG, outgoing ID width
- ARB_MODE, 1, 0 = round-robin only, 1 = QoS priority with round-robin tie-break
- AGE_W, 4, wait-counter width; aging threshold AGE_MAX = 2^AGE_W−1 cycles
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- awid_i, awaddr_i, awlen_i[8], awsize_i[3], awburst_i[2], awlock_i[1], awcache_i[4], awprot_i[3], awregion_i[4], awuser_i, awqos_i[4]  in  N_TARG_PORT×field  per-port AW payload
- awvalid_i  in  N_TARG_PORT  per-port request
- awready_o  out  N_TARG_PORT  per-port accept, one-hot or zero
- awid_o  out  AXI_ID_OUT  {winner binary index, awid}
- awaddr_o … awqos_o  out  field widths  registered payload
- awvalid_o  out  1  output stage valid
- awready_i  in  1  downstream accept
- push_ID_o  out  1  push strobe to the W allocator FIFO
- ID_o  out  LOG_N_TARG+N_TARG_PORT  {binary index, one-hot index} of the port accepted this cycle
- grant_FIFO_ID_i  in  1  W ID FIFO has space

## Operation
- **Effective priority.** With ARB_MODE=1, each port's priority is awqos_i, or 16 when its wait counter equals AGE_MAX. With ARB_MODE=0, all priorities are equal.
- **Winner selection.** Among valid ports, the highest effective priority wins. Ties go to the first port at or after rr_ptr, scanning upward with wrap modulo N_TARG_PORT.
- **Load condition.** load = win_valid & grant_FIFO_ID_i & (!awvalid_o | awready_i).
- **On load:**
  - awready_o[winner]=1 and push_ID_o=1.
  - ID_o carries the winner's index.
  - Payload and awid_o = {index, awid} are captured into the output register.
  - rr_ptr ← (winner+1) mod N_TARG_PORT. Wrap is explicit, since N_TARG_PORT need not be a power of two.
- **Without load:** awready_o=0, push_ID_o=0, ID_o=0.
- **Wait counters (per port):**
  - Cleared when the port is granted.
  - Incremented, saturating at AGE_MAX, on every cycle the port is valid and not granted.
  - Cleared when the port is not valid.
  - Counters are held constant when ARB_MODE=0.
- **Output register:**
  - awvalid_o is set on load.
  - It is cleared on awready_i & !load.
  - It stays set on awready_i & load, with new payload back-to-back.
- **Ordering.** Acceptance order equals push order equals AW issue order, so W ordering is preserved.
- **Grant and ready are decoupled.** grant_FIFO_ID_i=0 blocks new loads only. An already-registered request still drains on awready_i.
- **Payload stability.** The payload is not required to stay stable across losing cycles. The winner can change between cycles until a grant is given.

## Timing
- **Latency.** Request to awvalid_o is 1 cycle. Sustained throughput is 1 AW per cycle while awready_i=1.
- **Combinational paths.** awready_i → awready_o/push_ID_o, and grant_FIFO_ID_i → awready_o/push_ID_o. This is deliberate; no bubble on drain.
- **Reset values.** On rst_n low (asynchronous), in any state including mid-burst:
  - awvalid_o=0, all payload registers 0, rr_ptr=0, all wait counters 0.
  - awready_o=0 and push_ID_o=0, since no port is valid-qualified until reset is released.
- **No valid.** When no port is valid, rr_ptr and the output register hold.

## Structure
- **Package axi_node_pkg:**
  - ARB_RR/ARB_QOS constants.
  - QOS_AGED=5'd16.
  - AW payload width localparam function: AXI_ID_IN+AXI_ADDRESS_W+8+3+2+1+4+3+4+AXI_USER_W+4.
- **Sub-module axi_qos_rr_arbiter.** Parametrised on N and priority width. It performs masked priority selection plus rr_ptr update and outputs a one-hot and binary grant.
- **Top level.** Holds the wait counters, payload packing/unpacking, the output register and the push logic.

## Test plan
- **RR fairness.** ARB_MODE=0, N=8, all ports valid continuously, awready_i=1 → grants 0,1,…,7,0 on consecutive cycles; awid_o MSBs match; push_ID_o=1 every cycle.
- **QoS priority with tie-break.**
  - Stimulus: ARB_MODE=1; port 2 qos=3, port 5 qos=9, port 6 qos=9.
  - Response: port 5 then 6 win, then port 2. ID_o for port 5 = {3'd5, 8'b0010_0000}.
- **Aging.**
  - Stimulus: AGE_W=2; port 1 qos=0 held valid; ports 3 and 4 qos=15 refreshed continuously.
  - Response: port 1 is granted no later than the 4th cycle after its counter starts at 0, i.e. when the counter reaches 3.
- **FIFO backpressure.** grant_FIFO_ID_i=0 while awvalid_o=1 and awready_i=1 → registered request drains, no awready_o and no push; grant resumes on the cycle grant_FIFO_ID_i=1.
- **Downstream stall.** awready_i=0 for 5 cycles → awvalid_o and payload stable; no awready_o; one request accepted on the cycle awready_i returns.
- **Reset mid-operation.** Assert rst_n while awvalid_o=1 and counters are non-zero → all outputs 0 immediately; after release, arbitration restarts from port 0.
